// File: rtl/verdict_pkg.sv
// Shared types and constants for the verdict collector: record layout,
// header field offsets and the serializer state encoding.
package verdict_pkg;

    localparam int DEFAULT_DATA_W  = 64;
    localparam int DEFAULT_NUM_OUT = 3;
    localparam int DEFAULT_TS_W    = 32;
    localparam int DEFAULT_DEPTH   = 8;

    localparam int TS_LSB   = 0;
    localparam int MASK_LSB = 32;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    typedef struct packed {
        logic [DEFAULT_TS_W-1:0]                         ts;
        logic [DEFAULT_NUM_OUT-1:0]                      mask;
        logic [DEFAULT_NUM_OUT-1:0][DEFAULT_DATA_W-1:0]  vals;
    } verdict_rec_t;

endpackage

// File: rtl/verdict_collector_if.sv
// Ready/valid word stream carrying serialized verdict records.
interface verdict_collector_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/verdict_fifo.sv
// Single-clock record FIFO with full/empty flags and an occupancy count.
module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter type rec_t = verdict_rec_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rec_t                     din,
    input  logic                     pop,
    output rec_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic           do_push, do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/verdict_collector.sv
// Captures timestamped monitor verdicts into a FIFO and serializes each record
// as a header word followed by one word per active output.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int NUM_OUT = DEFAULT_NUM_OUT,
    parameter int TS_W    = DEFAULT_TS_W,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_OUT*DATA_W-1:0]  out_val,
    input  logic [NUM_OUT-1:0]         out_aktv,
    verdict_collector_if.master        m,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef struct packed {
        logic [TS_W-1:0]                 ts;
        logic [NUM_OUT-1:0]              mask;
        logic [NUM_OUT-1:0][DATA_W-1:0]  vals;
    } rec_t;

    state_t         state_q, state_d;
    rec_t           hold_q, hold_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [TS_W-1:0] ts_q, ts_d;

    rec_t           wr_rec, rd_rec;
    logic           capture, push, pop, hs, full, empty;
    logic [IW:0]    first, nxt;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [IW:0] next_set(input logic [NUM_OUT-1:0] mask, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] make_header(input logic [TS_W-1:0] ts,
                                                       input logic [NUM_OUT-1:0] mask);
        logic [DATA_W-1:0] h;
        h = '0;
        h[TS_LSB +: TS_W]      = ts;
        h[MASK_LSB +: NUM_OUT] = mask;
        return h;
    endfunction

    assign capture     = en & (|out_aktv);
    assign push        = capture & ~full;
    assign pop         = en & (state_q == IDLE) & ~empty;
    assign hs          = en & m.m_ready;
    assign wr_rec.ts   = ts_q;
    assign wr_rec.mask = out_aktv;
    assign wr_rec.vals = out_val;
    assign first       = next_set(hold_q.mask, 0);
    assign nxt         = next_set(hold_q.mask, int'(idx_q) + 1);
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

    verdict_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_rec),
        .pop   (pop),
        .dout  (rd_rec),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        ts_d       = en ? ts_q + 1'b1 : ts_q;
        m.m_valid  = 1'b0;
        m.m_last   = 1'b0;
        m.m_data   = '0;

        // Fullness is judged before this edge's pop, so a same-cycle pop cannot rescue the push.
        if (capture && full) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    hold_d  = rd_rec;
                    state_d = HDR;
                end
            end
            HDR: begin
                m.m_valid = 1'b1;
                m.m_data  = make_header(hold_q.ts, hold_q.mask);
                if (hs) begin
                    idx_d   = first[IW-1:0];
                    state_d = DATA;
                end
            end
            DATA: begin
                m.m_valid = 1'b1;
                m.m_data  = hold_q.vals[idx_q];
                m.m_last  = ~nxt[IW];
                if (hs) begin
                    if (nxt[IW]) idx_d = nxt[IW-1:0];
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            ts_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            ts_q       <= ts_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_verdict_collector.sv
// Scoreboard bench for verdict_collector: a record-level model predicts the
// word stream, and a monitor compares every completed handshake against it.
module tb_verdict_collector;
    localparam int DW    = 64;
    localparam int NO    = 3;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en  = 1'b0;
    logic [NO*DW-1:0]    out_val  = '0;
    logic [NO-1:0]       out_aktv = '0;
    logic                overflow;
    logic [15:0]         drop_cnt;
    logic [3:0]          fifo_level;

    verdict_collector_if #(.DATA_W(DW)) m_if ();

    verdict_collector #(
        .DATA_W  (DW),
        .NUM_OUT (NO),
        .TS_W    (32),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_val    (out_val),
        .out_aktv   (out_aktv),
        .m          (m_if),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t        exp_q[$];
    int           checks = 0;
    int           passed = 0;
    int           pushed = 0;
    int           done   = 0;
    logic [31:0]  ts_model = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [NO*DW-1:0] rnd_vals();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // A record is a header (ts, mask) followed by the active outputs in index order.
    task automatic expect_record(input logic [31:0] ts, input logic [NO-1:0] mask,
                                 input logic [NO*DW-1:0] vals);
        word_t w;
        int n;
        int k;
        n = $countones(mask);
        k = 0;
        w.data = '0;
        w.data[31:0]    = ts;
        w.data[32 +: NO] = mask;
        w.last = 1'b0;
        exp_q.push_back(w);
        for (int i = 0; i < NO; i++) begin
            if (mask[i]) begin
                k++;
                w.data = vals[i*DW +: DW];
                w.last = (k == n);
                exp_q.push_back(w);
            end
        end
        pushed++;
    endtask

    task automatic cycle(input bit e, input logic [NO-1:0] a, input logic [NO*DW-1:0] v,
                         input bit drop = 1'b0);
        en = e;
        out_aktv = a;
        out_val = v;
        if (e && a != '0 && !drop) expect_record(ts_model, a, v);
        @(posedge clk);
        if (e) ts_model = ts_model + 32'd1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, '0, rnd_vals());
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || m_if.m_valid) && c < budget) begin
            cycle(1'b1, '0, rnd_vals());
            c++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid_low", 64'(m_if.m_valid), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        word_t w;
        if (rst && en && m_if.m_valid && m_if.m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h expected no word", m_if.m_data);
            end else begin
                w = exp_q.pop_front();
                chk("word_data", m_if.m_data, w.data);
                chk("word_last", 64'(m_if.m_last), 64'(w.last));
                if (w.last) done++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NO*DW-1:0] v;
        logic [NO-1:0]    a;
        bit               e;
        int               n_en;

        m_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(m_if.m_valid), 64'd0);
        chk("rst_last", 64'(m_if.m_last), 64'd0);
        chk("rst_data", m_if.m_data, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b1;
        ts_model = '0;

        // Single capture at ts=1000.
        idle(1000);
        v = rnd_vals();
        v[63:0]   = 64'd1;
        v[127:64] = 64'd1;
        cycle(1'b1, 3'b011, v);
        drain(50);
        chk("single_level", 64'(fifo_level), 64'd0);

        // Sparse mask with a negative value.
        v = rnd_vals();
        v[191:128] = -64'sd5;
        cycle(1'b1, 3'b100, v);
        drain(50);

        // Back-pressure inside DATA.
        m_if.m_ready = 1'b0;
        cycle(1'b1, 3'b111, rnd_vals());
        cycle(1'b1, 3'b101, rnd_vals());
        m_if.m_ready = 1'b1;
        idle(1);
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("bp_valid", 64'(m_if.m_valid), 64'd1);
            chk("bp_data", m_if.m_data, exp_q[0].data);
            chk("bp_last", 64'(m_if.m_last), 64'(exp_q[0].last));
            chk("bp_level", 64'(fifo_level), 64'd1);
        end
        m_if.m_ready = 1'b1;
        drain(100);
        chk("bp_level_after", 64'(fifo_level), 64'd0);

        // Randomized traffic, throttled so the FIFO never fills.
        for (int i = 0; i < 600; i++) begin
            m_if.m_ready = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            if (pushed - done >= DEPTH) a = '0;
            cycle(e, a, rnd_vals());
        end
        m_if.m_ready = 1'b1;
        drain(600);
        chk("rand_overflow", 64'(overflow), 64'd0);
        chk("rand_drop_cnt", 64'(drop_cnt), 64'd0);

        // Overflow: ten back-to-back captures against a stalled sink.
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 3'($urandom_range(1, 7)), rnd_vals(), i == 9);
        end
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        m_if.m_ready = 1'b1;
        drain(200);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_drop_hold", 64'(drop_cnt), 64'd1);

        // en=0 while the header is presented.
        m_if.m_ready = 1'b0;
        cycle(1'b1, 3'b010, rnd_vals());
        idle(1);
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 3'($urandom_range(1, 7)), rnd_vals());
            chk("en_valid_hold", 64'(m_if.m_valid), 64'd1);
            chk("en_hdr_hold", m_if.m_data, exp_q[0].data);
        end
        drain(50);
        cycle(1'b1, 3'b001, rnd_vals());
        drain(50);

        // Asynchronous reset while a record is in DATA.
        m_if.m_ready = 1'b0;
        cycle(1'b1, 3'b111, rnd_vals());
        cycle(1'b1, 3'b011, rnd_vals());
        cycle(1'b1, 3'b110, rnd_vals());
        m_if.m_ready = 1'b1;
        idle(1);
        m_if.m_ready = 1'b0;
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(m_if.m_valid), 64'd0);
        chk("arst_last", 64'(m_if.m_last), 64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        pushed = 0;
        done = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ts_model = '0;
        n_en = 0;
        for (int i = 0; i < 15; i++) begin
            e = ($urandom_range(0, 2) != 0);
            if (e) n_en++;
            cycle(e, '0, rnd_vals());
        end
        chk("arst_ts_model", 64'(ts_model), 64'(n_en));
        m_if.m_ready = 1'b1;
        cycle(1'b1, 3'b101, rnd_vals());
        drain(50);
        chk("final_level", 64'(fifo_level), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
